game_controller: RTL and testbench
==================================

# game_controller

Control unit that sequences the guessing-game datapath. It loads the secret through `RNG_LOAD` and walks the three guessed digits through the datapath comparator via `N_SELECT`. From the returned `EQ_R*` flags it computes each digit's hint and writes it with `H*_ENABLE`/`H_SELECT`. It also counts attempts and declares win/lose; it is the control-side counterpart that consumes `EQ_R0..2` and produces every datapath load/select.

## Interface
- `MAX_ATTEMPTS`, 6: guesses allowed per game (≥1).
- `CLK` in 1: clock; only clock.
- `RST_N` in 1: reset, synchronous, active-low.
- `START` in 1: begin a new game.
- `GUESS_VALID` in 1: guess on `N0..N2` is valid; accepted when `READY`=1.
- `EQ_R0`, `EQ_R1`, `EQ_R2` in 1 each: datapath compare of the registered-selected digit against secret positions 0/1/2.
- `READY` out 1: waiting for a guess.
- `RNG_LOAD` out 1: capture secret.
- `H0_ENABLE`, `H1_ENABLE`, `H2_ENABLE` out 1 each: hint register loads.
- `H_SELECT` out 2: hint code (0 = absent 2'b00, 1 = present 2'b01, 2 = exact 2'b10).
- `N_SELECT` out 2: digit select (0 = zero, 1 = N2, 2 = N1, 3 = N0); the datapath registers it, so `EQ_R*` reflect it one cycle later.
- `WIN`, `LOSE` out 1 each: game result, held until next `START`.
- `ATTEMPTS` out $clog2(MAX_ATTEMPTS+1): guesses consumed this game.

## Operation
- States: IDLE, SEED, WAIT_GUESS, SEL0, EVAL0, SEL1, EVAL1, SEL2, EVAL2, DECIDE, WON, LOST.
- IDLE / WON / LOST:
  - `START` → SEED.
- SEED (1 cycle):
  - `RNG_LOAD`=1; all three `H*_ENABLE`=1 with `H_SELECT`=0 (clears hints).
  - Exact mask ← 0, `ATTEMPTS` ← 0.
  - → WAIT_GUESS.
- WAIT_GUESS:
  - `READY`=1.
  - `START` has priority: → SEED (restart).
  - Else `GUESS_VALID` → SEL0.
- SELi, for position i with code 3/2/1 for i=0/1/2:
  - `N_SELECT`=code(i).
  - → EVALi.
- EVALi:
  - `N_SELECT` held at code(i).
  - Hint = exact if `EQ_Ri`; else present if any other `EQ_Rj`; else absent.
  - `Hi_ENABLE`=1 with that `H_SELECT`; exact-mask bit i ← `EQ_Ri`.
  - → SEL(i+1), or DECIDE after EVAL2.
- DECIDE:
  - `ATTEMPTS` ← `ATTEMPTS`+1.
  - If mask==3'b111 → WON.
  - Else if `ATTEMPTS`+1 == `MAX_ATTEMPTS` → LOST.
  - Else → WAIT_GUESS.
- Duplicate digits: present-check takes no multiplicity into account; a digit is "present" if it equals any other secret position.
- `START` and `GUESS_VALID` are ignored in SEL*/EVAL*/DECIDE. `GUESS_VALID` is ignored in IDLE/WON/LOST.
- `N0..N2` must be stable from acceptance through EVAL2; the controller does not capture them.
- Outputs not stated above are 0 in every state. `N_SELECT`=0 outside SEL*/EVAL*.

## Timing
- Reset (`RST_N`=0 at a rising edge):
  - State → IDLE; `ATTEMPTS`=0, mask=0.
  - All outputs 0, including `READY`, `WIN` and `LOSE`.
  - Applies from any state, mid-evaluation included; no partial hint write occurs after the edge.
- `WIN`=1 in WON and `LOSE`=1 in LOST, registered from the state.
- Guess accepted at edge T (`READY`&`GUESS_VALID`):
  - SEL0 during T..T+1; `H0_ENABLE` during the EVAL0 cycle (T+1..T+2).
  - `H1_ENABLE` at T+3..T+4; `H2_ENABLE` at T+5..T+6.
  - DECIDE at T+6..T+7.
  - `READY`/`WIN`/`LOSE` valid from edge T+7.
- Guess-to-result latency: 7 cycles.
- `START` to `READY`: 2 edges (SEED, then WAIT_GUESS).
- `ATTEMPTS` never exceeds `MAX_ATTEMPTS`. Arithmetic is unsigned; compare against `MAX_ATTEMPTS` before increment, with no wrap.

## Structure
- `game_pkg`:
  - state enum;
  - `H_SELECT` codes (HSEL_ABSENT=0, HSEL_PRESENT=1, HSEL_EXACT=2);
  - `N_SELECT` codes (NSEL_ZERO=0, NSEL_N2=1, NSEL_N1=2, NSEL_N0=3);
  - shared with the datapath.
- One sub-module, `hint_encoder`: combinational; (position index, `EQ_R0..2`) → `H_SELECT` code.
- FSM, exact mask and attempt counter live in `game_controller`.

## Test plan
- Reset: hold `RST_N`=0 for 2 cycles, `START`=1 → all outputs 0, no `RNG_LOAD`. Release, pulse `START` → `RNG_LOAD`=1 for one cycle with `H0..2_ENABLE`=1 and `H_SELECT`=0; `READY`=1 next cycle.
- Exact win:
  - Stimulus: accept guess; `EQ`=3'b001 in EVAL0, 3'b010 in EVAL1, 3'b100 in EVAL2.
  - Response: `N_SELECT` = 3,2,1 in SEL/EVAL pairs; `H_SELECT`=2 at each enable.
  - Result: `WIN`=1 and `ATTEMPTS`=1 at T+7.
- Mixed hints:
  - Stimulus: `EQ`=3'b010 in EVAL0, 3'b000 in EVAL1, 3'b100 in EVAL2.
  - Response: `H_SELECT` 1, 0, 2 on `H0`,`H1`,`H2` enables.
  - Result: `READY`=1, `ATTEMPTS`=1.
- Lose: `MAX_ATTEMPTS`=6, six guesses with `EQ`=0 → `ATTEMPTS`=6, `LOSE`=1; further `GUESS_VALID` ignored; `START` → SEED, `ATTEMPTS`=0, `LOSE`=0.
- Priority: in WAIT_GUESS, `START`=`GUESS_VALID`=1 → SEED, not SEL0; `GUESS_VALID` pulses during EVAL1 → ignored, sequence unchanged.
- Mid-operation reset: `RST_N`=0 in EVAL1 → next cycle IDLE, `H1_ENABLE`=0, all outputs 0.

Source files
------------

// File: rtl/game_pkg.sv
// ------------------------------------------------------------------
// game_pkg: states and select codes shared by controller and datapath
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package game_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SEED       = 4'd1,
    S_WAIT_GUESS = 4'd2,
    S_SEL0       = 4'd3,
    S_EVAL0      = 4'd4,
    S_SEL1       = 4'd5,
    S_EVAL1      = 4'd6,
    S_SEL2       = 4'd7,
    S_EVAL2      = 4'd8,
    S_DECIDE     = 4'd9,
    S_WON        = 4'd10,
    S_LOST       = 4'd11
  } state_e;

  localparam logic [1:0] HSEL_ABSENT  = 2'd0;
  localparam logic [1:0] HSEL_PRESENT = 2'd1;
  localparam logic [1:0] HSEL_EXACT   = 2'd2;

  localparam logic [1:0] NSEL_ZERO = 2'd0;
  localparam logic [1:0] NSEL_N2   = 2'd1;
  localparam logic [1:0] NSEL_N1   = 2'd2;
  localparam logic [1:0] NSEL_N0   = 2'd3;

  // Guess position i is routed through the comparator via code 3 - i.
  function automatic logic [1:0] nsel_for_pos(input logic [1:0] pos);
    case (pos)
      2'd0:    nsel_for_pos = NSEL_N0;
      2'd1:    nsel_for_pos = NSEL_N1;
      2'd2:    nsel_for_pos = NSEL_N2;
      default: nsel_for_pos = NSEL_ZERO;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/hint_encoder.sv
// ------------------------------------------------------------------
// hint_encoder: maps a position and the EQ flags to a hint code
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hint_encoder (
  input  logic [1:0] pos_i,
  input  logic [2:0] eq_i,
  output logic [1:0] h_select_o
);
  import game_pkg::*;

  logic exact;
  logic elsewhere;

  // Multiplicity is deliberately ignored: any match at another position counts.
  always_comb begin
    exact     = 1'b0;
    elsewhere = 1'b0;
    case (pos_i)
      2'd0: begin
        exact     = eq_i[0];
        elsewhere = eq_i[1] | eq_i[2];
      end
      2'd1: begin
        exact     = eq_i[1];
        elsewhere = eq_i[0] | eq_i[2];
      end
      2'd2: begin
        exact     = eq_i[2];
        elsewhere = eq_i[0] | eq_i[1];
      end
      default: begin
        exact     = 1'b0;
        elsewhere = 1'b0;
      end
    endcase

    if (exact)
      h_select_o = HSEL_EXACT;
    else if (elsewhere)
      h_select_o = HSEL_PRESENT;
    else
      h_select_o = HSEL_ABSENT;
  end

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
// ------------------------------------------------------------------
// game_controller: sequences secret load, digit compare, hints, win/lose
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module game_controller #(
  parameter int unsigned MAX_ATTEMPTS = 6
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  start_i,
  input  logic                                  guess_valid_i,
  input  logic                                  eq_r0_i,
  input  logic                                  eq_r1_i,
  input  logic                                  eq_r2_i,
  output logic                                  ready_o,
  output logic                                  rng_load_o,
  output logic                                  h0_enable_o,
  output logic                                  h1_enable_o,
  output logic                                  h2_enable_o,
  output logic [1:0]                            h_select_o,
  output logic [1:0]                            n_select_o,
  output logic                                  win_o,
  output logic                                  lose_o,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempts_o
);
  import game_pkg::*;

  localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1);

  state_e        state_q, state_d;
  logic [AW-1:0] attempts_q, attempts_d;
  logic [2:0]    mask_q, mask_d;
  logic [2:0]    eq;
  logic [1:0]    eval_pos;
  logic [1:0]    hint_sel;

  assign eq         = {eq_r2_i, eq_r1_i, eq_r0_i};
  assign attempts_o = attempts_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      attempts_q <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      attempts_q <= attempts_d;
      mask_q     <= mask_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    attempts_d = attempts_q;
    mask_d     = mask_q;
    case (state_q)
      S_IDLE, S_WON, S_LOST: begin
        if (start_i) state_d = S_SEED;
      end
      S_SEED: begin
        attempts_d = '0;
        mask_d     = '0;
        state_d    = S_WAIT_GUESS;
      end
      S_WAIT_GUESS: begin
        if (start_i)            state_d = S_SEED;
        else if (guess_valid_i) state_d = S_SEL0;
      end
      S_SEL0: state_d = S_EVAL0;
      S_EVAL0: begin
        mask_d[0] = eq[0];
        state_d   = S_SEL1;
      end
      S_SEL1: state_d = S_EVAL1;
      S_EVAL1: begin
        mask_d[1] = eq[1];
        state_d   = S_SEL2;
      end
      S_SEL2: state_d = S_EVAL2;
      S_EVAL2: begin
        mask_d[2] = eq[2];
        state_d   = S_DECIDE;
      end
      S_DECIDE: begin
        // Losing is tested on the pre-increment count so the counter never wraps.
        attempts_d = attempts_q + AW'(1);
        if (mask_q == 3'b111)
          state_d = S_WON;
        else if (attempts_q == AW'(MAX_ATTEMPTS - 1))
          state_d = S_LOST;
        else
          state_d = S_WAIT_GUESS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      S_EVAL1: eval_pos = 2'd1;
      S_EVAL2: eval_pos = 2'd2;
      default: eval_pos = 2'd0;
    endcase
  end

  hint_encoder u_hint_encoder (
    .pos_i      (eval_pos),
    .eq_i       (eq),
    .h_select_o (hint_sel)
  );

  always_comb begin
    ready_o     = 1'b0;
    rng_load_o  = 1'b0;
    h0_enable_o = 1'b0;
    h1_enable_o = 1'b0;
    h2_enable_o = 1'b0;
    h_select_o  = HSEL_ABSENT;
    n_select_o  = NSEL_ZERO;
    win_o       = 1'b0;
    lose_o      = 1'b0;
    case (state_q)
      S_SEED: begin
        rng_load_o  = 1'b1;
        h0_enable_o = 1'b1;
        h1_enable_o = 1'b1;
        h2_enable_o = 1'b1;
      end
      S_WAIT_GUESS: ready_o = 1'b1;
      S_SEL0: n_select_o = nsel_for_pos(2'd0);
      S_EVAL0: begin
        n_select_o  = nsel_for_pos(2'd0);
        h0_enable_o = 1'b1;
        h_select_o  = hint_sel;
      end
      S_SEL1: n_select_o = nsel_for_pos(2'd1);
      S_EVAL1: begin
        n_select_o  = nsel_for_pos(2'd1);
        h1_enable_o = 1'b1;
        h_select_o  = hint_sel;
      end
      S_SEL2: n_select_o = nsel_for_pos(2'd2);
      S_EVAL2: begin
        n_select_o  = nsel_for_pos(2'd2);
        h2_enable_o = 1'b1;
        h_select_o  = hint_sel;
      end
      S_WON:  win_o  = 1'b1;
      S_LOST: lose_o = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// ------------------------------------------------------------------
// tb_game_controller: directed self-checking bench for game_controller
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_game_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       guess_valid = 1'b0;
  logic [2:0] eq = 3'b000;
  logic       ready, rng_load, h0, h1, h2, win, lose;
  logic [1:0] h_sel, n_sel;
  logic [2:0] attempts;

  int n_pass  = 0;
  int n_total = 0;

  // {ready, rng_load, h2, h1, h0, h_sel, n_sel, win, lose}
  wire [10:0] outs = {ready, rng_load, h2, h1, h0, h_sel, n_sel, win, lose};

  localparam logic [10:0] O_ZERO = 11'b0_0_000_00_00_0_0;
  localparam logic [10:0] O_SEED = 11'b0_1_111_00_00_0_0;
  localparam logic [10:0] O_WAIT = 11'b1_0_000_00_00_0_0;
  localparam logic [10:0] O_WON  = 11'b0_0_000_00_00_1_0;
  localparam logic [10:0] O_LOST = 11'b0_0_000_00_00_0_1;

  localparam logic [13:0] NS_EXP = 14'b11_11_10_10_01_01_00;
  localparam logic [20:0] EN_EXP = 21'b000_001_000_010_000_100_000;

  game_controller #(.MAX_ATTEMPTS(6)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .guess_valid_i (guess_valid),
    .eq_r0_i       (eq[0]),
    .eq_r1_i       (eq[1]),
    .eq_r2_i       (eq[2]),
    .ready_o       (ready),
    .rng_load_o    (rng_load),
    .h0_enable_o   (h0),
    .h1_enable_o   (h1),
    .h2_enable_o   (h2),
    .h_select_o    (h_sel),
    .n_select_o    (n_sel),
    .win_o         (win),
    .lose_o        (lose),
    .attempts_o    (attempts)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts a guess from WAIT_GUESS and walks SEL0..DECIDE, recording outputs per cycle.
  task automatic run_guess(input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2,
                           input logic noise, output logic [13:0] ns_tr,
                           output logic [20:0] en_tr, output logic [5:0] hs_tr);
    ns_tr = '0;
    en_tr = '0;
    hs_tr = '0;
    guess_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      guess_valid = noise && (c == 3);
      start       = noise && (c == 3);
      eq = (c < 2) ? e0 : (c < 4) ? e1 : (c < 6) ? e2 : 3'b000;
      #1;
      ns_tr = {ns_tr[11:0], n_sel};
      en_tr = {en_tr[17:0], h2, h1, h0};
      if (c == 1 || c == 3 || c == 5) hs_tr = {hs_tr[3:0], h_sel};
    end
    eq = 3'b000;
  endtask

  task automatic new_game;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; guess_valid = 1'b1; eq = 3'b111;
    tick();
    n_total++;
    if (outs !== O_ZERO) $display("FAIL reset_outs_1: got %b expected %b", outs, O_ZERO); else n_pass++;
    tick();
    n_total++;
    if (outs !== O_ZERO) $display("FAIL reset_outs_2: got %b expected %b", outs, O_ZERO); else n_pass++;
    n_total++;
    if (attempts !== 3'd0) $display("FAIL reset_attempts: got %0d expected 0", attempts); else n_pass++;
    rst_n = 1'b1; eq = 3'b000;
    tick();
    n_total++;
    if (outs !== O_SEED) $display("FAIL reset_seed: got %b expected %b", outs, O_SEED); else n_pass++;
    start = 1'b0; guess_valid = 1'b0;
    tick();
    n_total++;
    if (outs !== O_WAIT) $display("FAIL reset_ready: got %b expected %b", outs, O_WAIT); else n_pass++;
  endtask

  task automatic test_exact_win;
    logic [13:0] ns; logic [20:0] en; logic [5:0] hs;
    run_guess(3'b001, 3'b010, 3'b100, 1'b0, ns, en, hs);
    n_total++;
    if (ns !== NS_EXP) $display("FAIL win_nsel: got %b expected %b", ns, NS_EXP); else n_pass++;
    n_total++;
    if (en !== EN_EXP) $display("FAIL win_enables: got %b expected %b", en, EN_EXP); else n_pass++;
    n_total++;
    if (hs !== 6'b10_10_10) $display("FAIL win_hints: got %b expected 101010", hs); else n_pass++;
    tick();
    n_total++;
    if (outs !== O_WON) $display("FAIL win_result: got %b expected %b", outs, O_WON); else n_pass++;
    n_total++;
    if (attempts !== 3'd1) $display("FAIL win_attempts: got %0d expected 1", attempts); else n_pass++;
  endtask

  task automatic test_mixed_hints;
    logic [13:0] ns; logic [20:0] en; logic [5:0] hs;
    new_game();
    n_total++;
    if (outs !== O_WAIT || attempts !== 3'd0)
      $display("FAIL mixed_restart: got %b/%0d expected %b/0", outs, attempts, O_WAIT);
    else n_pass++;
    run_guess(3'b010, 3'b000, 3'b100, 1'b0, ns, en, hs);
    n_total++;
    if (hs !== 6'b01_00_10) $display("FAIL mixed_hints: got %b expected 010010", hs); else n_pass++;
    tick();
    n_total++;
    if (outs !== O_WAIT) $display("FAIL mixed_result: got %b expected %b", outs, O_WAIT); else n_pass++;
    n_total++;
    if (attempts !== 3'd1) $display("FAIL mixed_attempts: got %0d expected 1", attempts); else n_pass++;
  endtask

  task automatic test_priority;
    logic [13:0] ns; logic [20:0] en; logic [5:0] hs;
    start = 1'b1; guess_valid = 1'b1;
    tick();
    n_total++;
    if (outs !== O_SEED) $display("FAIL prio_start_wins: got %b expected %b", outs, O_SEED); else n_pass++;
    start = 1'b0; guess_valid = 1'b0;
    tick();
    n_total++;
    if (outs !== O_WAIT || attempts !== 3'd0)
      $display("FAIL prio_ready: got %b/%0d expected %b/0", outs, attempts, O_WAIT);
    else n_pass++;
    run_guess(3'b001, 3'b010, 3'b100, 1'b1, ns, en, hs);
    start = 1'b0; guess_valid = 1'b0;
    n_total++;
    if (ns !== NS_EXP || en !== EN_EXP)
      $display("FAIL prio_noise_seq: got %b/%b expected %b/%b", ns, en, NS_EXP, EN_EXP);
    else n_pass++;
    tick();
    n_total++;
    if (outs !== O_WON || attempts !== 3'd1)
      $display("FAIL prio_noise_result: got %b/%0d expected %b/1", outs, attempts, O_WON);
    else n_pass++;
  endtask

  task automatic test_lose;
    logic [13:0] ns; logic [20:0] en; logic [5:0] hs;
    new_game();
    for (int k = 0; k < 6; k++) begin
      run_guess(3'b000, 3'b000, 3'b000, 1'b0, ns, en, hs);
      tick();
      n_total++;
      if (k < 5) begin
        if (outs !== O_WAIT || attempts !== 3'(k + 1))
          $display("FAIL lose_step%0d: got %b/%0d expected %b/%0d", k, outs, attempts, O_WAIT, k + 1);
        else n_pass++;
      end else begin
        if (outs !== O_LOST || attempts !== 3'd6)
          $display("FAIL lose_final: got %b/%0d expected %b/6", outs, attempts, O_LOST);
        else n_pass++;
      end
    end
    n_total++;
    if (hs !== 6'b00_00_00) $display("FAIL lose_hints: got %b expected 000000", hs); else n_pass++;
    guess_valid = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if (outs !== O_LOST || attempts !== 3'd6)
      $display("FAIL lose_ignore_guess: got %b/%0d expected %b/6", outs, attempts, O_LOST);
    else n_pass++;
    start = 1'b1;
    tick();
    n_total++;
    if (outs !== O_SEED) $display("FAIL lose_restart_seed: got %b expected %b", outs, O_SEED); else n_pass++;
    start = 1'b0; guess_valid = 1'b0;
    tick();
    n_total++;
    if (outs !== O_WAIT || attempts !== 3'd0)
      $display("FAIL lose_restart_ready: got %b/%0d expected %b/0", outs, attempts, O_WAIT);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    logic [13:0] ns; logic [20:0] en; logic [5:0] hs;
    run_guess(3'b000, 3'b000, 3'b000, 1'b0, ns, en, hs);
    tick();
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tick(); tick();
    eq = 3'b010;
    tick();
    n_total++;
    if (h1 !== 1'b1 || n_sel !== 2'd2 || h_sel !== 2'd2)
      $display("FAIL midrst_eval1: got h1=%b nsel=%0d hsel=%0d expected 1/2/2", h1, n_sel, h_sel);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    n_total++;
    if (outs !== O_ZERO || attempts !== 3'd0)
      $display("FAIL midrst_outs: got %b/%0d expected %b/0", outs, attempts, O_ZERO);
    else n_pass++;
    rst_n = 1'b1; eq = 3'b000;
    tick();
    n_total++;
    if (outs !== O_ZERO) $display("FAIL midrst_idle: got %b expected %b", outs, O_ZERO); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exact_win();
    test_mixed_hints();
    test_priority();
    test_lose();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
